// File: rtl/psram_burst_arbiter.sv
// Shares one PSRAM burst controller between NPORT requesters: grants one burst at a time,
// issues the latched command and steers controller strobes back to the owner only.
module psram_burst_arbiter #(
    parameter int          NPORT     = 5,
    parameter int          AW        = 23,
    parameter int          LW        = 11,
    parameter int unsigned PRIO_MASK = 32'h14,
    parameter int          WDOG      = 4096
) (
    input  logic                xClk,
    input  logic                reset_n,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT-1:0]    rnw,
    input  logic [NPORT*AW-1:0] addr,
    input  logic [NPORT*LW-1:0] blen,
    output logic [NPORT-1:0]    write_next,
    output logic [NPORT-1:0]    dout_valid,
    output logic [NPORT-1:0]    done,
    output logic [NPORT-1:0]    grant,
    input  logic                ram_ready,
    output logic                ram_req,
    output logic                ram_rnw,
    output logic [AW-1:0]       ram_addr,
    output logic [LW-1:0]       ram_blen,
    input  logic                ram_wnext,
    input  logic                ram_dvalid,
    input  logic                ram_done,
    output logic                wdog_err
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int WW = $clog2(WDOG + 1);
    localparam logic [NPORT-1:0] PRIO = PRIO_MASK[NPORT-1:0];

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic [NPORT-1:0]  grant_q, grant_d;
    logic [NPORT-1:0]  done_q, done_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic              wdog_err_q, wdog_err_d;
    logic              rnw_q, rnw_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LW-1:0]     blen_q, blen_d;

    logic              found, win_hp;
    logic [PW-1:0]     win_idx, rr_next;
    logic [PW:0]       rr_idx;
    logic [NPORT-1:0]  win_oh;
    logic [LW-1:0]     win_blen;

    // Winner: lowest-index high-priority requester, else first request at/after rr_ptr.
    always_comb begin
        found   = 1'b0;
        win_hp  = 1'b0;
        win_idx = '0;
        rr_idx  = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (!found && req[i] && PRIO[i]) begin
                found   = 1'b1;
                win_hp  = 1'b1;
                win_idx = PW'(i);
            end
        end
        for (int k = 0; k < NPORT; k++) begin
            rr_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (rr_idx >= (PW+1)'(NPORT))
                rr_idx = rr_idx - (PW+1)'(NPORT);
            if (!found && req[rr_idx[PW-1:0]]) begin
                found   = 1'b1;
                win_idx = rr_idx[PW-1:0];
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = found;
        rr_next         = (win_idx == PW'(NPORT - 1)) ? '0 : win_idx + PW'(1);
        win_blen        = blen[int'(win_idx)*LW +: LW];
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = '0;
        rr_ptr_d   = rr_ptr_q;
        wdog_d     = wdog_q;
        wdog_err_d = wdog_err_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        blen_d     = blen_q;
        unique case (state_q)
            IDLE: begin
                if (ram_ready && found) begin
                    grant_d = win_oh;
                    rnw_d   = rnw[win_idx];
                    addr_d  = addr[int'(win_idx)*AW +: AW];
                    blen_d  = (win_blen == '0) ? LW'(1) : win_blen;
                    wdog_d  = '0;
                    if (!win_hp)
                        rr_ptr_d = rr_next;
                    state_d = ISSUE;
                end
            end
            ISSUE, BUSY: begin
                wdog_d = wdog_q + WW'(1);
                if (ram_done) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = DONE;
                end else if (wdog_q == WW'(WDOG - 1)) begin
                    // Hung controller: release the owner as if the burst had finished.
                    done_d     = grant_q;
                    grant_d    = '0;
                    wdog_err_d = 1'b1;
                    state_d    = DONE;
                end else if (state_q == ISSUE && !ram_ready) begin
                    state_d = BUSY;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge xClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            rr_ptr_q   <= '0;
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            blen_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            rr_ptr_q   <= rr_ptr_d;
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_err_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            blen_q     <= blen_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign wdog_err   = wdog_err_q;
    assign ram_req    = (state_q == ISSUE);
    assign ram_rnw    = rnw_q;
    assign ram_addr   = addr_q;
    assign ram_blen   = blen_q;
    assign write_next = grant_q & {NPORT{ram_wnext}};
    assign dout_valid = grant_q & {NPORT{ram_dvalid}};

endmodule
